control_banderin: RTL and testbench
===================================

CONTROL_BANDERIN -- requirements
Module: control_banderin

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CLK_FREQ_HZ, 25_000_000, clk frequency in Hz; CLK_FREQ_HZ/1000 is an integer ≥ 2.
- MIN_HOLD_MS, 500, servo settle time in ms; ≥ 1.
- TIMEOUT_MS, 300_000, race time limit in ms; range 1 to 2^20-1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock, 25 MHz.
- reset, input, 1, synchronous active-high reset, sampled on rising clk.
- btn_start, input, 1, start/re-arm button; asynchronous level, already debounced.
- sensor_meta, input, 1, finish-line sensor; asynchronous level.
- btn_abort, input, 1, abort button; asynchronous level.
- comando_banderin, output, 1, to servo PWM generator; 1 = flag up (90°), 0 = flag down (0°).
- estado, output, 2, FSM state code.
- tiempo_ms, output, 20, elapsed race time in ms.
- timeout, output, 1, last race ended by time limit.
- fin_pulso, output, 1, single-cycle pulse on entry to FIN.
REQ-003 The design SHALL use one clock domain (clk) with a synchronous active-high reset (reset); no other clock or asynchronous reset is used.

Function
REQ-004 Each of btn_start, sensor_meta and btn_abort SHALL pass through a 2-FF synchronizer, then a rising-edge detector (sync2 & ~prev).
- Latency: an input first sampled high at edge N SHALL produce registered output changes at edge N+2.
REQ-005 The FSM SHALL have four states: IDLE=2'd0, ARMADO=2'd1, CARRERA=2'd2, FIN=2'd3.
- estado SHALL equal the current state code.
REQ-006 comando_banderin SHALL be a registered output: 1 in ARMADO and CARRERA, 0 in IDLE and FIN.
REQ-007 A ms prescaler SHALL count 0 to CLK_FREQ_HZ/1000-1 and emit a 1-cycle tick on the terminal count.
- It SHALL clear on every state transition.
REQ-008 A hold counter SHALL count ticks since entry to ARMADO or FIN.
- It SHALL clear on entry; its width SHALL be sufficient for MIN_HOLD_MS.
REQ-009 IDLE transition: start edge SHALL go to ARMADO, clearing tiempo_ms and timeout.
REQ-010 ARMADO behaviour:
- tiempo_ms SHALL increment on each tick.
- After MIN_HOLD_MS ticks the FSM SHALL go to CARRERA.
- Sensor edges in ARMADO SHALL be ignored (not latched).
REQ-011 CARRERA behaviour:
- tiempo_ms SHALL increment on each tick.
- A sensor edge SHALL go to FIN with timeout=0.
- When tiempo_ms would reach TIMEOUT_MS, the FSM SHALL go to FIN with tiempo_ms=TIMEOUT_MS and timeout=1.
REQ-012 Sensor edge and tick in the same cycle SHALL apply the increment and finish by sensor, provided the incremented value is < TIMEOUT_MS; otherwise the finish is a timeout.
REQ-013 FIN behaviour:
- tiempo_ms and timeout SHALL hold.
- Start edges SHALL be ignored until MIN_HOLD_MS ticks have elapsed since entry.
- After that, a start edge SHALL go to ARMADO, clearing tiempo_ms and timeout.
REQ-014 fin_pulso SHALL be 1 for exactly the first cycle in which estado=FIN.
REQ-015 An abort edge in any state SHALL go to IDLE on the next edge, clearing tiempo_ms, timeout, the hold counter and the prescaler.
- Abort SHALL take priority over simultaneous start, sensor or timeout.
REQ-016 Start edges in ARMADO or CARRERA SHALL be ignored.
REQ-017 Held inputs SHALL have no effect beyond their single rising edge.
REQ-018 tiempo_ms SHALL never exceed TIMEOUT_MS and SHALL never wrap.

Reset
REQ-019 While reset=1 at a rising clk, the block SHALL load all of the following to 0 on that edge:
- estado=IDLE, comando_banderin, tiempo_ms, timeout, fin_pulso.
- Prescaler, hold counter, synchronizer and edge-detector flops.
REQ-020 Reset asserted mid-race SHALL abandon the race; no fin_pulso SHALL be emitted.
REQ-021 Inputs held high through reset release SHALL NOT produce an edge.

Verification
Bench parameters: CLK_FREQ_HZ=10_000 (10 cycles/tick), MIN_HOLD_MS=3, TIMEOUT_MS=20.
REQ-022 Scenario: reset, then start pulse.
- Required: comando_banderin=1 and estado=1, two edges after sampling.
- Required: estado=2 after 30 cycles.
REQ-023 Scenario: sensor pulse at tiempo_ms=7.
- Required: estado=3, comando_banderin=0, fin_pulso high for one cycle, tiempo_ms=7, timeout=0.
REQ-024 Scenario: no sensor input.
- Required: at tiempo_ms=20, estado=3 and timeout=1; tiempo_ms stays 20 for 100 further cycles.
REQ-025 Scenario: sensor pulse during ARMADO at tick 1.
- Required: ignored; estado reaches 2 at tick 3.
REQ-026 Scenario: in FIN, start at tick 1, then start at tick 4.
- Required: first ignored; second gives estado=1 and tiempo_ms=0.
REQ-027 Scenario: abort and sensor asserted in the same cycle during CARRERA.
- Required: estado=0, tiempo_ms=0, no fin_pulso.
- Required: same outcome for reset mid-CARRERA.

Source files
------------

// File: rtl/control_banderin.sv
// rtl/control_banderin.sv - race start/finish flag controller with ms timer and timeout
//
// Ports:
//   clk               sole clock
//   reset             synchronous active-high reset
//   btn_start         start / re-arm button, asynchronous debounced level
//   sensor_meta       finish-line sensor, asynchronous level
//   btn_abort         abort button, asynchronous level
//   comando_banderin  flag command to servo PWM: 1 = up (90 deg), 0 = down (0 deg)
//   estado            FSM state code: IDLE=0 ARMADO=1 CARRERA=2 FIN=3
//   tiempo_ms         elapsed race time in ms, saturates at TIMEOUT_MS
//   timeout           last race ended by the time limit
//   fin_pulso         one-cycle pulse on entry to FIN

module control_banderin #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int MIN_HOLD_MS = 500,
  parameter int TIMEOUT_MS  = 300_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        sensor_meta,
  input  logic        btn_abort,
  output logic        comando_banderin,
  output logic [1:0]  estado,
  output logic [19:0] tiempo_ms,
  output logic        timeout,
  output logic        fin_pulso
);

  localparam int DIV = CLK_FREQ_HZ / 1000;
  localparam int PW  = $clog2(DIV);
  localparam int HW  = $clog2(MIN_HOLD_MS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(MIN_HOLD_MS);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(MIN_HOLD_MS - 1);
  localparam logic [20:0]   TMO        = 21'(TIMEOUT_MS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMADO  = 2'd1,
    CARRERA = 2'd2,
    FIN     = 2'd3
  } state_t;

  state_t state;

  // Input synchronizers and edge detectors; bit order {abort, sensor, start}.
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] prev;
  logic [1:0] warm;
  logic [2:0] edges;
  logic       start_e;
  logic       sensor_e;
  logic       abort_e;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      warm  <= '0;
    end else begin
      sync1 <= {btn_abort, sensor_meta, btn_start};
      sync2 <= sync1;
      prev  <= sync2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  // The cleared prev flop would make a level held through reset look like a
  // rising edge; edges are masked until prev has caught up with sync2.
  assign edges    = (warm == 2'd3) ? (sync2 & ~prev) : 3'b000;
  assign start_e  = edges[0];
  assign sensor_e = edges[1];
  assign abort_e  = edges[2];

  // Millisecond timebase and race time arithmetic.
  logic [PW-1:0] presc;
  logic [HW-1:0] hold;
  logic          tick;
  logic [20:0]   t_inc;
  logic [19:0]   t_step;
  logic          t_limit;

  assign tick    = (presc == PRESC_LAST);
  assign t_inc   = {1'b0, tiempo_ms} + 21'd1;
  // Increment on tick but never past the limit.
  assign t_step  = (tick && (t_inc <= TMO)) ? t_inc[19:0] : tiempo_ms;
  // The limit wins over a sensor edge when the incremented value reaches it.
  assign t_limit = (tick && (t_inc >= TMO)) || ({1'b0, tiempo_ms} >= TMO);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      comando_banderin <= 1'b0;
      tiempo_ms        <= '0;
      timeout          <= 1'b0;
      fin_pulso        <= 1'b0;
      presc            <= '0;
      hold             <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick && (hold != HOLD_MAX)) hold <= hold + HW'(1);
      fin_pulso <= 1'b0;

      if (abort_e) begin
        state            <= IDLE;
        comando_banderin <= 1'b0;
        tiempo_ms        <= '0;
        timeout          <= 1'b0;
        presc            <= '0;
        hold             <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_e) begin
              state            <= ARMADO;
              comando_banderin <= 1'b1;
              tiempo_ms        <= '0;
              timeout          <= 1'b0;
              presc            <= '0;
              hold             <= '0;
            end
          end

          ARMADO: begin
            tiempo_ms <= t_step;
            if (tick && (hold == HOLD_LAST)) begin
              state <= CARRERA;
              presc <= '0;
            end
          end

          CARRERA: begin
            if (t_limit) begin
              state            <= FIN;
              comando_banderin <= 1'b0;
              tiempo_ms        <= TMO[19:0];
              timeout          <= 1'b1;
              fin_pulso        <= 1'b1;
              presc            <= '0;
              hold             <= '0;
            end else if (sensor_e) begin
              state            <= FIN;
              comando_banderin <= 1'b0;
              tiempo_ms        <= t_step;
              timeout          <= 1'b0;
              fin_pulso        <= 1'b1;
              presc            <= '0;
              hold             <= '0;
            end else begin
              tiempo_ms <= t_step;
            end
          end

          FIN: begin
            if (start_e && (hold == HOLD_MAX)) begin
              state            <= ARMADO;
              comando_banderin <= 1'b1;
              tiempo_ms        <= '0;
              timeout          <= 1'b0;
              presc            <= '0;
              hold             <= '0;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_control_banderin.sv
// tb/tb_control_banderin.sv - self-checking bench for control_banderin

module tb_control_banderin;

  logic        clk;
  logic        reset;
  logic        btn_start;
  logic        sensor_meta;
  logic        btn_abort;
  logic        comando_banderin;
  logic [1:0]  estado;
  logic [19:0] tiempo_ms;
  logic        timeout;
  logic        fin_pulso;

  int checks   = 0;
  int failures = 0;

  control_banderin #(
    .CLK_FREQ_HZ(10_000),
    .MIN_HOLD_MS(3),
    .TIMEOUT_MS (20)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .btn_start       (btn_start),
    .sensor_meta     (sensor_meta),
    .btn_abort       (btn_abort),
    .comando_banderin(comando_banderin),
    .estado          (estado),
    .tiempo_ms       (tiempo_ms),
    .timeout         (timeout),
    .fin_pulso       (fin_pulso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record: pulse the flagged inputs for one edge, advance w edges,
  // then compare outputs and the number of fin_pulso cycles seen.
  typedef struct {
    string name;
    bit    rst;
    bit    start;
    bit    sensor;
    bit    abort;
    int    w;
    int    est;
    int    cmd;
    int    t;
    int    tmo;
    int    fin;
    int    fins;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(string n, bit r, bit s, bit se, bit a, int w,
                              int est, int cmd, int t, int tmo, int fin, int fins);
    vec_t v;
    v.name = n; v.rst = r; v.start = s; v.sensor = se; v.abort = a; v.w = w;
    v.est = est; v.cmd = cmd; v.t = t; v.tmo = tmo; v.fin = fin; v.fins = fins;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    int   fins;
    fins = 0;
    exp_q.push_back(v);
    if (v.rst)    reset       = 1'b1;
    if (v.start)  btn_start   = 1'b1;
    if (v.sensor) sensor_meta = 1'b1;
    if (v.abort)  btn_abort   = 1'b1;
    for (int i = 0; i < v.w; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        if (v.rst)    reset       = 1'b0;
        if (v.start)  btn_start   = 1'b0;
        if (v.sensor) sensor_meta = 1'b0;
        if (v.abort)  btn_abort   = 1'b0;
      end
      if (fin_pulso === 1'b1) fins++;
    end
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard_empty actual=0 required=1", v.name);
    end else begin
      e = exp_q.pop_front();
      cmp({e.name, "/estado"},           32'(estado),           32'(e.est));
      cmp({e.name, "/comando_banderin"}, 32'(comando_banderin), 32'(e.cmd));
      cmp({e.name, "/tiempo_ms"},        32'(tiempo_ms),        32'(e.t));
      cmp({e.name, "/timeout"},          32'(timeout),          32'(e.tmo));
      cmp({e.name, "/fin_pulso"},        32'(fin_pulso),        32'(e.fin));
      cmp({e.name, "/fin_count"},        32'(fins),             32'(e.fins));
    end
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    btn_start   = 1'b0;
    sensor_meta = 1'b0;
    btn_abort   = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    //          name            rst st se ab   w  est cmd  t tmo fin fins
    vecs.push_back(mk("reset_state",  1, 0, 0, 0,   1, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk("idle_quiet",   0, 0, 0, 0,   5, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk("start_arm",    0, 1, 0, 0,   3, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk("arm_t2",       0, 0, 0, 0,  28, 1, 1,  2, 0, 0, 0));
    vecs.push_back(mk("arm_to_race",  0, 0, 0, 0,   2, 2, 1,  3, 0, 0, 0));
    vecs.push_back(mk("race_t7",      0, 0, 0, 0,  40, 2, 1,  7, 0, 0, 0));
    vecs.push_back(mk("sensor_fin",   0, 0, 1, 0,   3, 3, 0,  7, 0, 1, 1));
    vecs.push_back(mk("fin_one_cyc",  0, 0, 0, 0,   1, 3, 0,  7, 0, 0, 0));
    vecs.push_back(mk("fin_tick1",    0, 0, 0, 0,  10, 3, 0,  7, 0, 0, 0));
    vecs.push_back(mk("start_early",  0, 1, 0, 0,   3, 3, 0,  7, 0, 0, 0));
    vecs.push_back(mk("fin_tick4",    0, 0, 0, 0,  27, 3, 0,  7, 0, 0, 0));
    vecs.push_back(mk("start_rearm",  0, 1, 0, 0,   3, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk("arm_tick1",    0, 0, 0, 0,  10, 1, 1,  1, 0, 0, 0));
    vecs.push_back(mk("sensor_armado",0, 0, 1, 0,   3, 1, 1,  1, 0, 0, 0));
    vecs.push_back(mk("arm_tick3",    0, 0, 0, 0,  17, 2, 1,  3, 0, 0, 0));
    vecs.push_back(mk("race_t19",     0, 0, 0, 0, 160, 2, 1, 19, 0, 0, 0));
    vecs.push_back(mk("race_pre_tmo", 0, 0, 0, 0,   9, 2, 1, 19, 0, 0, 0));
    vecs.push_back(mk("timeout_fin",  0, 0, 0, 0,   1, 3, 0, 20, 1, 1, 1));
    vecs.push_back(mk("timeout_hold", 0, 0, 0, 0, 100, 3, 0, 20, 1, 0, 0));
    vecs.push_back(mk("rearm_clrtmo", 0, 1, 0, 0,   3, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk("race3",        0, 0, 0, 0,  30, 2, 1,  3, 0, 0, 0));
    vecs.push_back(mk("race3_pre",    0, 0, 0, 0,   7, 2, 1,  3, 0, 0, 0));
    vecs.push_back(mk("sensor_tick",  0, 0, 1, 0,   3, 3, 0,  4, 0, 1, 1));
    vecs.push_back(mk("fin3_hold",    0, 0, 0, 0,  40, 3, 0,  4, 0, 0, 0));
    vecs.push_back(mk("rearm4",       0, 1, 0, 0,   3, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk("race4",        0, 0, 0, 0,  30, 2, 1,  3, 0, 0, 0));
    vecs.push_back(mk("race4_t19",    0, 0, 0, 0, 167, 2, 1, 19, 0, 0, 0));
    vecs.push_back(mk("sensor_at_lim",0, 0, 1, 0,   3, 3, 0, 20, 1, 1, 1));
    vecs.push_back(mk("fin4_hold",    0, 0, 0, 0,  40, 3, 0, 20, 1, 0, 0));
    vecs.push_back(mk("rearm5",       0, 1, 0, 0,   3, 1, 1,  0, 0, 0, 0));
    vecs.push_back(mk("race5",        0, 0, 0, 0,  30, 2, 1,  3, 0, 0, 0));
    vecs.push_back(mk("race5_t5",     0, 0, 0, 0,  20, 2, 1,  5, 0, 0, 0));
    vecs.push_back(mk("abort_sensor", 0, 0, 1, 1,   3, 0, 0,  0, 0, 0, 0));
    vecs.push_back(mk("after_abort",  0, 0, 0, 0,  30, 0, 0,  0, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Abort held high: only its rising edge acts, a later start still arms.
    btn_abort = 1'b1;
    apply(mk("abort_held",     0, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0));
    apply(mk("start_abort_hi", 0, 1, 0, 0,  3, 1, 1, 0, 0, 0, 0));
    btn_abort = 1'b0;

    // Reset in the middle of a race abandons it with no finish pulse.
    apply(mk("race6",          0, 0, 0, 0, 30, 2, 1, 3, 0, 0, 0));
    apply(mk("race6_t5",       0, 0, 0, 0, 20, 2, 1, 5, 0, 0, 0));
    apply(mk("reset_mid_race", 1, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0));

    // Start held high through reset release must not arm.
    btn_start = 1'b1;
    apply(mk("start_thru_rst", 1, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0));
    btn_start = 1'b0;
    apply(mk("start_release",  0, 0, 0, 0,  3, 0, 0, 0, 0, 0, 0));
    apply(mk("start_after_rst",0, 1, 0, 0,  3, 1, 1, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
